// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction RAM address and
// registers each fetched word into IF/ID; halts once execution reaches address 0.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        active,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_vld_p1;
  logic        w_vld_nxt;
  logic [31:0] r_instr_p1;
  logic [31:0] r_pc_p1;
  logic [31:0] r_fetch_count;
  logic        w_pc_zero;
  logic        w_advance;

  assign w_pc_zero = (r_pc == 32'd0);
  assign w_advance = (r_state == ST_RUN) && !w_pc_zero && !stall;

  // Redirect is only honoured on an advancing edge; the delay-slot word at
  // branch+4 is fetched on that same edge, so nothing is ever squashed.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_vld_nxt   = r_vld_p1;
    case (r_state)
      ST_RUN: begin
        if (w_pc_zero) begin
          w_state_nxt = ST_DRAIN;
        end else if (!stall) begin
          w_pc_nxt  = redirect ? redirect_target : seq_pc(r_pc);
          w_vld_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_vld_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_HALT;
        w_vld_nxt   = 1'b0;
        w_pc_nxt    = 32'd0;
      end
    endcase
  end

  // Stage p0 -> p1: PC/control update and IF/ID capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_VECTOR;
      r_vld_p1      <= 1'b0;
      r_instr_p1    <= 32'd0;
      r_pc_p1       <= 32'd0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_vld_p1 <= w_vld_nxt;
      if (w_advance) begin
        r_instr_p1    <= instr_readdata;
        r_pc_p1       <= r_pc;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign instr_address = r_pc;
  assign if_valid      = r_vld_p1;
  assign if_instr      = r_instr_p1;
  assign if_pc         = r_pc_p1;
  assign fetch_count   = r_fetch_count;
  assign halted        = (r_state == ST_HALT);
  assign active        = rst_n && (r_state != ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus queues expected IF/ID contents,
// a monitor pops and compares each new instruction decode is handed.
module tb_instr_fetch;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [1:0]  M_RUN = 2'd0, M_DRAIN = 2'd1, M_HALT = 2'd2;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        active;
  logic        halted;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];
  logic [63:0] e;
  logic        mon_last_vld = 1'b0;
  logic [31:0] mon_last_pc  = 32'd0;

  logic [31:0] m_pc  = RV;
  logic [31:0] m_cnt = 32'd0;
  logic        m_vld = 1'b0;
  logic [1:0]  m_state = M_RUN;

  instr_fetch #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .active(active), .halted(halted), .fetch_count(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program: addiu, addiu, lhu, lhu, sw, sw, jr r0, nop; elsewhere a distinct pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h24010001;
      32'hBFC00004: return 32'h24020002;
      32'hBFC00008: return 32'h94030000;
      32'hBFC0000C: return 32'h94040002;
      32'hBFC00010: return 32'hAC030010;
      32'hBFC00014: return 32'hAC040014;
      32'hBFC00018: return 32'h00000008;
      32'hBFC0001C: return 32'h00000000;
      default:      return a ^ 32'h5A5A5A5A;
    endcase
  endfunction

  always_comb instr_readdata = mem_word(instr_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic drive_cycle(input logic rn, input logic s, input logic r, input logic [31:0] t);
    rst_n = rn; stall = s; redirect = r; redirect_target = t;
    @(negedge clk);
    chk("instr_address", instr_address, m_pc);
    chk("fetch_count", fetch_count, m_cnt);
    chk1("if_valid", if_valid, m_vld);
    chk1("active", active, rn && (m_state != M_HALT));
    chk1("halted", halted, m_state == M_HALT);
    if (!rn) begin
      m_pc = RV; m_cnt = 32'd0; m_vld = 1'b0; m_state = M_RUN;
    end else begin
      case (m_state)
        M_RUN: begin
          if (m_pc == 32'd0) begin
            m_state = M_DRAIN;
          end else if (!s) begin
            sb.push_back({m_pc, mem_word(m_pc)});
            m_vld = 1'b1;
            m_cnt = m_cnt + 32'd1;
            m_pc  = r ? t : m_pc + 32'd4;
          end
        end
        M_DRAIN: if (!s) begin m_vld = 1'b0; m_state = M_HALT; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (if_valid === 1'b1 && (!mon_last_vld || if_pc !== mon_last_pc)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got if_pc %h, want no new instruction", if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_if_pc", if_pc, e[63:32]);
        chk("sb_if_instr", if_instr, e[31:0]);
      end
    end
    mon_last_vld = (if_valid === 1'b1);
    mon_last_pc  = if_pc;
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
    @(posedge clk);
    #1;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_addr", instr_address, RV);

    // Sequential fetch, then stall while BFC00004 sits in IF/ID
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("seq_if_pc", if_pc, 32'hBFC00004);
    chk("seq_count", fetch_count, 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      chk("stall_if_pc", if_pc, 32'hBFC00004);
      chk("stall_addr", instr_address, 32'hBFC00008);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("resume_if_pc", if_pc, 32'hBFC00008);
    chk("resume_count", fetch_count, 32'd3);

    // Branch in IF/ID at BFC00008: delay slot BFC0000C then target
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hBFC00040);
    chk("dslot_if_pc", if_pc, 32'hBFC0000C);
    chk("dslot_if_instr", if_instr, 32'h94040002);
    chk("br_addr", instr_address, 32'hBFC00040);
    chk("four_count", fetch_count, 32'd4);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("tgt_if_pc", if_pc, 32'hBFC00040);

    // Redirect held under stall only takes effect on the unstalled edge
    drive_cycle(1'b1, 1'b1, 1'b1, 32'hBFC00080);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'hBFC00080);
    chk("rstall_addr", instr_address, 32'hBFC00044);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hBFC00080);
    chk("rstall_taken", instr_address, 32'hBFC00080);
    chk("rstall_if_pc", if_pc, 32'hBFC00044);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);

    // Misaligned target loads unchanged; then wrap FFFFFFFC+4 -> 0
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hBFC00102);
    chk("misalign_addr", instr_address, 32'hBFC00102);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr", instr_address, 32'd0);
    chk("wrap_count", fetch_count, 32'd11);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'hBFC00200);
    chk1("drain_valid", if_valid, 1'b1);
    chk1("drain_active", active, 1'b1);

    // Reset while draining, with a redirect pending
    drive_cycle(1'b0, 1'b0, 1'b1, 32'hBFC00200);
    chk("mid_rst_addr", instr_address, RV);
    chk("mid_rst_count", fetch_count, 32'd0);

    // jr r0 program
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'd0);
    chk("nop_if_pc", if_pc, 32'hBFC0001C);
    chk("nop_if_instr", if_instr, 32'd0);
    chk1("nop_valid", if_valid, 1'b1);
    chk("halt_count", fetch_count, 32'd8);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk1("drain_halted", halted, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk1("drain_hold_valid", if_valid, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk1("halt_valid", if_valid, 1'b0);
    chk1("halt_active", active, 1'b0);
    chk1("halt_halted", halted, 1'b1);
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b0, i[0], RV);
    chk1("halt_sticky", halted, 1'b1);
    chk("halt_pc", instr_address, 32'd0);
    chk("halt_count_hold", fetch_count, 32'd8);

    // Reset out of HALT and restart
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk1("unhalt", halted, 1'b0);
    chk("unhalt_addr", instr_address, RV);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("restart_if_pc", if_pc, 32'hBFC00008);
    chk("restart_if_instr", if_instr, 32'h94030000);
    chk("restart_count", fetch_count, 32'd3);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("sb_left", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
